// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package ifetch_pkg;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int ENTRY_W    = DEF_DATA_W + DEF_ADDR_W;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries; flush empties it in one cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int W     = ENTRY_W,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one word per cycle into a skid FIFO, handles redirect and halt.
// Define IFETCH_PERF_EN to add saturating handshake/stall counters.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RESET_PC   = 0,
    parameter int FIFO_DEPTH = 2,
    parameter int END_ADDR   = 249
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_instr,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] END_PC  = ADDR_W'(END_ADDR);

    state_t                   state, state_nx;
    logic [ADDR_W-1:0]        fetch_pc, inflight_pc;
    logic                     inflight;
    logic [CW-1:0]            count, occ;
    logic                     pop, push, issue;
    logic [DATA_W+ADDR_W-1:0] head;

    assign mem_addr  = fetch_pc;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // Returning word is dropped when a redirect lands in the same cycle.
    assign push      = inflight & ~redir_valid;
    // Issue only when the returning word is guaranteed a FIFO slot.
    assign occ       = count + CW'(inflight);
    assign issue     = (state == ST_RUN) && !redir_valid &&
                       ((occ < DEPTH_C) || ((occ == DEPTH_C) && pop));
    assign halted    = (state == ST_HALTED);
    assign out_instr = head[ADDR_W +: DATA_W];
    assign out_pc    = head[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (redir_valid) begin
            state_nx = ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (issue && fetch_pc == END_PC) state_nx = ST_DRAIN;
                ST_DRAIN: if (!inflight && count == '0)    state_nx = ST_HALTED;
                default:  state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RST_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redir_valid) begin
            fetch_pc <= redir_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

    ifetch_fifo #(
        .W     (DATA_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redir_valid),
        .push  (push),
        .pop   (pop),
        .din   ({mem_instr, inflight_pc}),
        .dout  (head),
        .count (count)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (out_valid && !out_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed scenarios plus random ready/redirect traffic, checked against an in-order stream model.
module tb_ifetch_ctrl;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int ENDA  = 249;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_instr = '0;
    logic          redir_valid;
    logic [AW-1:0] redir_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          halted;
`ifdef IFETCH_PERF_EN
    logic [31:0]   perf_fetched, perf_stall;
`endif

    ifetch_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .FIFO_DEPTH(DEPTH), .END_ADDR(ENDA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_instr   (mem_instr),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .halted      (halted)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: word k holds 0x1000_0000 + k, one-cycle registered read.
    logic [DW-1:0] mem [512];
    initial for (int k = 0; k < 512; k++) mem[k] = 32'h1000_0000 + k;
    always @(posedge clk) mem_instr <= mem[mem_addr];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: delivered words form a consecutive pc stream starting at the last
    // reset/redirect target and ending at ENDA; at most DEPTH words are ever outstanding.
    int      exp_pc   = 0;
    bit      exp_done = 1'b0;
    longint  m_fetched = 0;
    longint  m_stall   = 0;
    int      outst;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc    = 0;
            exp_done  = 1'b0;
            m_fetched = 0;
            m_stall   = 0;
        end else begin
`ifdef IFETCH_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_stall", perf_stall, m_stall);
`endif
            outst = (int'(mem_addr) - exp_pc + 512) % 512;
            chk("outstanding_le_depth", outst <= DEPTH, 1);
            if (exp_done) chk("valid_after_end", out_valid, 0);
            if (halted)   chk("halted_before_end", exp_done, 1);
            if (out_valid && out_ready && !exp_done) begin
                chk("stream_pc", out_pc, exp_pc);
                chk("stream_instr", out_instr, mem[exp_pc]);
                if (exp_pc == ENDA) exp_done = 1'b1;
                exp_pc = (exp_pc + 1) % 512;
                m_fetched++;
            end else if (out_valid && !out_ready) begin
                m_stall++;
            end
            if (redir_valid) begin
                exp_pc   = int'(redir_addr);
                exp_done = 1'b0;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input int pc);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_pc"}, out_pc, pc);
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] addr);
        drive_edge();
        redir_valid = 1'b1;
        redir_addr  = addr;
        drive_edge();
        redir_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; out_ready = 1'b0; redir_valid = 1'b0; redir_addr = '0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_halted", halted, 0);

        // Streaming: first valid two cycles after release, then one word per cycle
        drive_edge();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk("first_valid_c0", out_valid, 0);
        @(negedge clk); chk("first_valid_c1", out_valid, 0);
        for (int i = 0; i < 20; i++) begin
            expect_word("stream", i);
        end

        // Backpressure: head holds at 20, issue stops at 22
        drive_edge();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("bp_head_pc", out_pc, 20);
            chk("bp_valid", out_valid, 1);
            chk("bp_mem_addr", mem_addr, 22);
        end
        drive_edge();
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Async reset with FIFO full
        drive_edge();
        out_ready = 1'b0;
        repeat (4) drive_edge();
        chk("full_before_reset", out_valid, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_halted", halted, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_out_pc", out_pc, 0);
`ifdef IFETCH_PERF_EN
        chk("arst_perf_fetched", perf_fetched, 0);
        chk("arst_perf_stall", perf_stall, 0);
`endif
        drive_edge();
        rst = 1'b0; out_ready = 1'b1;

        // Redirect to 27 while pc 5 is at the head and 6 is in flight
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_pc == 4) && n < 20);
        chk("reach_pc4", out_pc, 4);
        pulse_redirect(9'd27);
        @(negedge clk); chk("redir_flush_c1", out_valid, 0);
        @(negedge clk); chk("redir_flush_c2", out_valid, 0);
        expect_word("redir_target", 27);

        // Halt: 247..249 delivered, then halted one cycle after FIFO drains
        pulse_redirect(9'd247);
        @(negedge clk);
        @(negedge clk);
        expect_word("halt_247", 247);
        expect_word("halt_248", 248);
        expect_word("halt_249", 249);
        @(negedge clk);
        chk("drain_valid", out_valid, 0);
        chk("drain_halted", halted, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("halted_flag", halted, 1);
            chk("halted_valid", out_valid, 0);
            chk("halted_mem_addr", mem_addr, 250);
        end

        // Exit HALTED with a redirect that wraps 511 -> 0
        drive_edge();
        redir_valid = 1'b1; redir_addr = 9'd510;
        @(negedge clk); chk("halted_during_redir", halted, 1);
        drive_edge();
        redir_valid = 1'b0;
        @(negedge clk); chk("halted_cleared", halted, 0);
        @(negedge clk);
        expect_word("wrap_510", 510);
        expect_word("wrap_511", 511);
        expect_word("wrap_0", 0);

        // Random ready / redirect traffic
        for (int c = 0; c < 2000; c++) begin
            drive_edge();
            out_ready   = ($urandom_range(0, 3) != 0);
            redir_valid = ($urandom_range(0, 39) == 0);
            redir_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(235, 249))
                                                      : AW'($urandom_range(0, 511));
        end
        drive_edge();
        redir_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the synchronous instruction memory (9-bit word address, 32-bit data, one-cycle registered read).
- Owns the fetch PC and issues one word address per cycle while buffer space exists.
- Tags each returned word with its PC and delivers it to decode through a valid/ready skid FIFO.
- Handles redirects (branch/jump) and end-of-program halt.

Parameters:
ADDR_W, 9, word-address width of the instruction memory
DATA_W, 32, instruction width
RESET_PC, 0, first word address fetched after reset
FIFO_DEPTH, 2, output buffer entries (power of two, >=2)
END_ADDR, 249, word address at which fetch stops (program-end marker)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
mem_addr  output  ADDR_W  word address to instruction memory, sampled by memory at clk edge
mem_instr  input  DATA_W  registered instruction from memory, valid one cycle after address issue
redir_valid  input  1  redirect request, single-cycle pulse or held
redir_addr  input  ADDR_W  redirect target word address
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts (handshake fires on out_valid & out_ready)
out_instr  output  DATA_W  instruction at FIFO head
out_pc  output  ADDR_W  word address of out_instr
halted  output  1  fetch stopped at END_ADDR and FIFO drained

Behaviour:
- Reset: fetch_pc=RESET_PC, inflight=0, FIFO empty, state=RUN. Outputs: mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
- mem_addr is always driven combinationally from fetch_pc. The memory reads every cycle; the controller ignores data it did not issue.
- Issue condition (cycle n): state==RUN, no redirect this cycle, (count + inflight) < FIFO_DEPTH, or == FIFO_DEPTH with a pop this cycle.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 mod 2^ADDR_W (wraps 511->0).
  - With no issue: inflight<=0.
- Return (cycle n+1): if inflight==1, push {mem_instr, inflight_pc} into the FIFO. Space is guaranteed by the issue rule, so there is no overflow.
- Throughput: sustained 1 instruction/cycle when out_ready is held high. First out_valid asserts 2 cycles after reset release.
- FIFO:
  - out_valid = count!=0; head entry drives out_instr/out_pc.
  - Simultaneous push and pop keep count unchanged.
  - Pop from empty cannot occur (gated by out_valid).
- Redirect (redir_valid=1 in cycle r):
  - FIFO flushed (count=0), inflight cleared (its returning word is dropped), fetch_pc<=redir_addr, state<=RUN (exits HALT/HALTED), halted<=0.
  - No issue in cycle r. Target issued in r+1, delivered at r+2.
  - Redirect beats push/pop in the same cycle; a handshake firing in cycle r still counts as consumed.
- States:
  - RUN: normal fetching.
  - RUN->DRAIN when an issue occurs with fetch_pc==END_ADDR. The END_ADDR word itself is fetched and delivered.
  - DRAIN: no issue; wait until inflight==0 and FIFO empty.
  - DRAIN->HALTED: halted=1 from the next cycle.
  - HALTED: no issue, out_valid=0. Only a redirect or reset leaves it.
- Reset mid-operation: asynchronous clear of all state to reset values. Any memory data in flight is discarded.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (handshakes completed) and perf_stall[31:0] (cycles with out_valid=1 & out_ready=0).
  - Both reset to 0, saturate at 32'hFFFFFFFF, and are not cleared by redirect.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package ifetch_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2;
  - default ADDR_W/DATA_W;
  - the fetch-entry struct/width constant {instr, pc} = DATA_W+ADDR_W bits.
- One sub-module: ifetch_fifo (synchronous FIFO, flush input, push/pop, count output).
- PC/issue/state logic stays in ifetch_ctrl.

Test Plan:
- Streaming: release reset, memory holds word k = 32'h1000_0000+k, out_ready=1 → out_valid rises 2 cycles after reset; pcs 0,1,2,… consecutive, one per cycle, instr matches.
- Backpressure: out_ready=0 for 6 cycles after first valid → at most FIFO_DEPTH (2) entries held, mem issue stops, no loss/duplication; resuming yields the in-order pc sequence.
- Redirect: pulse redir_valid with redir_addr=9'd27 while words at pc 5,6 are buffered/in flight → pc 5,6 never delivered after the redirect; next delivered out_pc=27, two cycles after the pulse.
- Halt: redirect to 247 with out_ready=1 → pcs 247,248,249 delivered; no issue of 250; halted=1 one cycle after FIFO empties; out_valid stays 0.
- Wrap and exit: redirect from HALTED to 510 → halted drops; pcs 510,511,0 delivered.
- Async reset mid-stream: assert rst between clock edges with FIFO full → out_valid=0, halted=0, mem_addr=RESET_PC immediately; with IFETCH_PERF_EN, counters read 0.
